nanci_pe_sort: RTL and testbench
================================

Name: nanci_pe_sort

Overview:
Second-generation Nanci mesh processing element. It performs a complete snake-order shearsort step sequence on one {addr,data} word, using compare-exchange with its four mesh neighbours.
- The word is loaded through a valid/ready port, not from a memory file.
- Sorting starts on a broadcast start pulse, and the block reports completion with a done pulse.
- Row position, column position, mesh size, phase count and compare key are set by parameters.
- One instance sits at each mesh node. All nodes share clk, rst and i_start, so the whole mesh runs in lockstep.

Parameters:
ADDR_WIDTH, 3, width of the address field (upper bits of the word)
DATA_WIDTH, 3, width of the data field (lower bits of the word)
SQRT_N, 2, mesh side length
ROW, 0, row index of this PE (0 is the top row)
COL, 0, column index of this PE (0 is the left column)
PHASE_CYCLES, 2, compare-exchange steps per phase
NUM_PHASES, 3, total phases; must be odd; even-numbered phases are ROW phases, odd-numbered phases are COL phases
KEY_MODE, 0, compare key: 0 = data field, 1 = addr field, 2 = full word
MAX_INT, all ones (W bits), reset/empty word value
(local) W = ADDR_WIDTH+DATA_WIDTH

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset (rst=0 resets on the rising edge of clk)
i_load_valid  in  1  load request
i_load_word  in  W  word to load
o_load_ready  out  1  high only in IDLE
i_start  in  1  sort start pulse
o_busy  out  1  high during ROW and COL phases
o_done  out  1  one-cycle completion pulse
i_PE_l, i_PE_r, i_PE_u, i_PE_d  in  W  neighbour words; each is the o_PE of the adjacent PE
o_PE  out  W  current word (registered)

Behaviour:
- Reset (rst=0 at a clock edge):
  - word = MAX_INT, state = IDLE, step and phase counters = 0.
  - o_busy=0, o_done=0, o_load_ready=1.
  - Reset has priority over everything, including mid-sort and mid-load.
- FSM states: IDLE, SORT, DONE.
- IDLE:
  - If i_load_valid is high, word <= i_load_word on that edge.
  - If i_start is high, go to SORT with step=0 and phase=0.
  - If load and start arrive on the same edge, both are taken; the first compare uses the loaded word.
- SORT, one compare-exchange per edge:
  - ROW phase:
    - Partner is R if (COL+step) is even, otherwise L.
    - Even row (ascending): partner R keeps min, partner L keeps max.
    - Odd row (descending): partner R keeps max, partner L keeps min.
  - COL phase:
    - Partner is D if (ROW+step) is even, otherwise U.
    - Partner D keeps min, partner U keeps max.
  - Edge nodes: if the partner does not exist (COL==0 with L, COL==SQRT_N-1 with R, ROW==0 with U, ROW==SQRT_N-1 with D), the word is held.
  - Ties: compare only the KEY_MODE field. On equal keys the PE keeps its own word, so a word is never duplicated.
  - Counters: step increments each edge and wraps at PHASE_CYCLES-1, which advances phase.
  - On the edge that writes the final compare (phase=NUM_PHASES-1, step=PHASE_CYCLES-1), go to DONE.
  - i_start and i_load_valid are ignored while in SORT.
- DONE lasts one cycle: o_done=1, o_busy=0, o_load_ready=0, and o_PE already holds the final word. Next state is IDLE.
- Timing: with i_start sampled at edge t0, o_busy=1 for NUM_PHASES*PHASE_CYCLES cycles starting after t0, and o_done=1 for one cycle after that.
- o_PE always equals the word register; it is never combinational from the neighbour inputs.

Decomposition:
- Package nanci_pkg:
  - state enum (IDLE/SORT/DONE)
  - KEY_MODE constants (KEY_DATA=0, KEY_ADDR=1, KEY_FULL=2)
  - PHASE_ROW/PHASE_COL encoding
  - function key_of(word, mode)
- Sub-module nanci_cmp_sel: combinational block with inputs own word, partner word, keep_min and valid partner. It outputs the next word and applies the tie and edge-hold rules.

Test Plan:
1. Reset: hold rst=0 for 2 cycles -> o_PE=6'b111111, o_busy=0, o_done=0, o_load_ready=1.
2. Load only: i_load_valid=1, i_load_word=6'b000101 for one edge in IDLE -> o_PE=6'b000101 next cycle; i_start held at 0 -> o_busy stays 0.
3. Ascending row swap, with ROW=0, COL=0, NUM_PHASES=1, PHASE_CYCLES=1, KEY_MODE=0:
   - Stimulus: load 6'b010110, i_PE_r=6'b001011, pulse start.
   - Response: o_PE=6'b001011 one edge after start, o_done=1 in that same cycle, then IDLE.
4. Tie, same setup with KEY_MODE=1: load 6'b011001, i_PE_r=6'b011111, pulse start -> o_PE stays 6'b011001 and o_done pulses.
5. Descending row, with ROW=1, COL=0, NUM_PHASES=1, PHASE_CYCLES=1: load 6'b001011, i_PE_r=6'b010110, start -> o_PE=6'b010110 (keeps max).
6. Full sequence with defaults (SQRT_N=2, 3 phases, 2 steps each):
   - Stimulus: load 6'b000111, i_PE_r=6'b001010, i_PE_d=6'b010001, start.
   - Required o_PE sequence: 001010, hold, 010001, hold, 010001, hold.
   - o_busy=1 for 6 cycles, then o_done=1 with o_PE=6'b010001.
   - A second start pulse during busy is ignored.
   - Variant: drive rst=0 during phase 1 -> next edge o_PE=6'b111111, o_busy=0, and o_done never asserts.

Source files
------------

// File: rtl/nanci_pkg.sv
// Shared types, constants and key extraction for the Nanci shearsort processing element.
package nanci_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSort,
        StDone
    } state_e;

    localparam int unsigned KEY_DATA = 0;
    localparam int unsigned KEY_ADDR = 1;
    localparam int unsigned KEY_FULL = 2;

    // Phase parity: even phases sort rows, odd phases sort columns.
    localparam logic PHASE_ROW = 1'b0;
    localparam logic PHASE_COL = 1'b1;

    localparam int unsigned KEY_MAX_W = 32;

    // Word is zero-extended to KEY_MAX_W by the caller.
    function automatic logic [KEY_MAX_W-1:0] key_of(input logic [KEY_MAX_W-1:0] word,
                                                    input int unsigned data_w,
                                                    input int unsigned mode);
        logic [KEY_MAX_W-1:0] mask;
        mask = ~({KEY_MAX_W{1'b1}} << data_w);
        case (mode)
            KEY_DATA: return word & mask;
            KEY_ADDR: return word >> data_w;
            default:  return word;
        endcase
    endfunction

endpackage

// File: rtl/nanci_cmp_sel.sv
// Compare-exchange selector: picks own or partner word by key, holding on ties
// and when the partner does not exist.
module nanci_cmp_sel
    import nanci_pkg::*;
#(
    parameter int unsigned W          = 6,
    parameter int unsigned DATA_WIDTH = 3,
    parameter int unsigned KEY_MODE   = 0
) (
    input  logic [W-1:0] own_word,
    input  logic [W-1:0] partner_word,
    input  logic         keep_min,
    input  logic         partner_valid,
    output logic [W-1:0] next_word
);

    logic [KEY_MAX_W-1:0] own_key;
    logic [KEY_MAX_W-1:0] partner_key;

    always_comb begin
        own_key     = key_of(KEY_MAX_W'(own_word), DATA_WIDTH, KEY_MODE);
        partner_key = key_of(KEY_MAX_W'(partner_word), DATA_WIDTH, KEY_MODE);
        next_word   = own_word;
        // Strict compares so equal keys keep the own word and nothing is duplicated.
        if (partner_valid) begin
            if (keep_min && (partner_key < own_key)) begin
                next_word = partner_word;
            end else if (!keep_min && (partner_key > own_key)) begin
                next_word = partner_word;
            end
        end
    end

endmodule

// File: rtl/nanci_pe_sort.sv
// Nanci mesh PE: loads one word, then runs a lockstep snake-order shearsort
// against its four neighbours on a broadcast start pulse.
module nanci_pe_sort
    import nanci_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 3,
    parameter int unsigned DATA_WIDTH   = 3,
    parameter int unsigned SQRT_N       = 2,
    parameter int unsigned ROW          = 0,
    parameter int unsigned COL          = 0,
    parameter int unsigned PHASE_CYCLES = 2,
    parameter int unsigned NUM_PHASES   = 3,
    parameter int unsigned KEY_MODE     = 0,
    parameter logic [ADDR_WIDTH+DATA_WIDTH-1:0] MAX_INT = '1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_load_valid,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0]   i_load_word,
    output logic                               o_load_ready,
    input  logic                               i_start,
    output logic                               o_busy,
    output logic                               o_done,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0]   i_PE_l,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0]   i_PE_r,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0]   i_PE_u,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0]   i_PE_d,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0]   o_PE
);

    localparam int unsigned W  = ADDR_WIDTH + DATA_WIDTH;
    localparam int unsigned SW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam int unsigned PW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
    localparam logic ROW_ODD = ((ROW % 2) == 1);
    localparam logic COL_ODD = ((COL % 2) == 1);
    localparam logic HAS_L   = (COL != 0);
    localparam logic HAS_R   = (COL != SQRT_N - 1);
    localparam logic HAS_U   = (ROW != 0);
    localparam logic HAS_D   = (ROW != SQRT_N - 1);

    state_e          state_q, state_d;
    logic [SW-1:0]   step_q, step_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [W-1:0]    word_q, word_d;

    logic [W-1:0]    partner_word;
    logic            keep_min;
    logic            partner_valid;
    logic [W-1:0]    cmp_word;
    logic            use_first;
    logic            step_last;
    logic            phase_last;

    // Partner alternates with step parity offset by position (R/D on even sums).
    always_comb begin
        partner_word  = i_PE_r;
        keep_min      = 1'b1;
        partner_valid = 1'b0;
        if (phase_q[0] == PHASE_ROW) begin
            use_first     = ((COL_ODD ^ step_q[0]) == 1'b0);
            partner_word  = use_first ? i_PE_r : i_PE_l;
            partner_valid = use_first ? HAS_R : HAS_L;
            keep_min      = use_first ^ ROW_ODD;
        end else begin
            use_first     = ((ROW_ODD ^ step_q[0]) == 1'b0);
            partner_word  = use_first ? i_PE_d : i_PE_u;
            partner_valid = use_first ? HAS_D : HAS_U;
            keep_min      = use_first;
        end
    end

    nanci_cmp_sel #(
        .W          (W),
        .DATA_WIDTH (DATA_WIDTH),
        .KEY_MODE   (KEY_MODE)
    ) u_cmp_sel (
        .own_word      (word_q),
        .partner_word  (partner_word),
        .keep_min      (keep_min),
        .partner_valid (partner_valid),
        .next_word     (cmp_word)
    );

    assign step_last  = (step_q == SW'(PHASE_CYCLES - 1));
    assign phase_last = (phase_q == PW'(NUM_PHASES - 1));

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        phase_d = phase_q;
        word_d  = word_q;
        unique case (state_q)
            StIdle: begin
                if (i_load_valid) begin
                    word_d = i_load_word;
                end
                if (i_start) begin
                    state_d = StSort;
                    step_d  = '0;
                    phase_d = '0;
                end
            end
            StSort: begin
                word_d = cmp_word;
                if (step_last) begin
                    step_d  = '0;
                    phase_d = phase_q + PW'(1);
                    if (phase_last) begin
                        state_d = StDone;
                    end
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            step_q  <= '0;
            phase_q <= '0;
            word_q  <= MAX_INT;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            phase_q <= phase_d;
            word_q  <= word_d;
        end
    end

    assign o_PE         = word_q;
    assign o_load_ready = (state_q == StIdle);
    assign o_busy       = (state_q == StSort);
    assign o_done       = (state_q == StDone);

endmodule

// File: tb/tb_nanci_pe_sort.sv
// Directed bench for nanci_pe_sort: several parameterised instances share clk, rst,
// start and load, each with its own static neighbour words.
module tb_nanci_pe_sort;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       lv  = 1'b0;
    logic [5:0] lw  = 6'b0;
    logic       st  = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [5:0] MAXW = 6'b111111;

    // Default instance: ROW=0, COL=0, 3 phases x 2 steps, data key.
    logic [5:0] def_pe;
    logic       def_busy, def_done, def_ready;
    // Single-step instances for the swap, tie and descending-row cases.
    logic [5:0] a_pe, t_pe, d_pe;
    logic       a_busy, a_done, a_ready;
    logic       t_busy, t_done, t_ready;
    logic       d_busy, d_done, d_ready;

    always #5 clk = ~clk;

    nanci_pe_sort dut_def (
        .clk (clk), .rst (rst), .i_load_valid (lv), .i_load_word (lw),
        .o_load_ready (def_ready), .i_start (st), .o_busy (def_busy), .o_done (def_done),
        .i_PE_l (MAXW), .i_PE_r (6'b001010), .i_PE_u (MAXW), .i_PE_d (6'b010001),
        .o_PE (def_pe)
    );

    nanci_pe_sort #(.NUM_PHASES(1), .PHASE_CYCLES(1), .KEY_MODE(0)) dut_a (
        .clk (clk), .rst (rst), .i_load_valid (lv), .i_load_word (lw),
        .o_load_ready (a_ready), .i_start (st), .o_busy (a_busy), .o_done (a_done),
        .i_PE_l (MAXW), .i_PE_r (6'b001011), .i_PE_u (MAXW), .i_PE_d (MAXW),
        .o_PE (a_pe)
    );

    nanci_pe_sort #(.NUM_PHASES(1), .PHASE_CYCLES(1), .KEY_MODE(1)) dut_t (
        .clk (clk), .rst (rst), .i_load_valid (lv), .i_load_word (lw),
        .o_load_ready (t_ready), .i_start (st), .o_busy (t_busy), .o_done (t_done),
        .i_PE_l (MAXW), .i_PE_r (6'b011111), .i_PE_u (MAXW), .i_PE_d (MAXW),
        .o_PE (t_pe)
    );

    nanci_pe_sort #(.ROW(1), .NUM_PHASES(1), .PHASE_CYCLES(1)) dut_d (
        .clk (clk), .rst (rst), .i_load_valid (lv), .i_load_word (lw),
        .o_load_ready (d_ready), .i_start (st), .o_busy (d_busy), .o_done (d_done),
        .i_PE_l (MAXW), .i_PE_r (6'b010110), .i_PE_u (MAXW), .i_PE_d (MAXW),
        .o_PE (d_pe)
    );

    // Load and start on the same edge; returns at the falling edge after it.
    task automatic load_and_start(input logic [5:0] w);
        @(negedge clk);
        lv = 1'b1; lw = w; st = 1'b1;
        @(negedge clk);
        lv = 1'b0; st = 1'b0;
    endtask

    task automatic settle();
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++; if (def_pe !== 6'b111111) begin n_fail++; $display("FAIL reset_pe got=%b exp=111111", def_pe); end
        n_tests++; if (def_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", def_busy); end
        n_tests++; if (def_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", def_done); end
        n_tests++; if (def_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", def_ready); end
        n_tests++; if (a_pe !== 6'b111111) begin n_fail++; $display("FAIL reset_pe_a got=%b exp=111111", a_pe); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load();
        lv = 1'b1; lw = 6'b000101;
        @(negedge clk);
        lv = 1'b0;
        n_tests++; if (def_pe !== 6'b000101) begin n_fail++; $display("FAIL load_pe got=%b exp=000101", def_pe); end
        n_tests++; if (def_busy !== 1'b0) begin n_fail++; $display("FAIL load_busy got=%b exp=0", def_busy); end
        @(negedge clk);
        n_tests++; if (def_busy !== 1'b0) begin n_fail++; $display("FAIL load_busy2 got=%b exp=0", def_busy); end
        n_tests++; if (def_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready got=%b exp=1", def_ready); end
    endtask

    task automatic test_asc_swap();
        load_and_start(6'b010110);
        n_tests++; if (a_pe !== 6'b010110) begin n_fail++; $display("FAIL asc_loaded got=%b exp=010110", a_pe); end
        n_tests++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL asc_busy got=%b exp=1", a_busy); end
        @(negedge clk);
        n_tests++; if (a_pe !== 6'b001011) begin n_fail++; $display("FAIL asc_pe got=%b exp=001011", a_pe); end
        n_tests++; if (a_done !== 1'b1) begin n_fail++; $display("FAIL asc_done got=%b exp=1", a_done); end
        n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL asc_busy_end got=%b exp=0", a_busy); end
        n_tests++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL asc_ready_done got=%b exp=0", a_ready); end
        @(negedge clk);
        n_tests++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL asc_done_pulse got=%b exp=0", a_done); end
        n_tests++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL asc_idle got=%b exp=1", a_ready); end
        settle();
    endtask

    task automatic test_tie();
        load_and_start(6'b011001);
        @(negedge clk);
        n_tests++; if (t_pe !== 6'b011001) begin n_fail++; $display("FAIL tie_pe got=%b exp=011001", t_pe); end
        n_tests++; if (t_done !== 1'b1) begin n_fail++; $display("FAIL tie_done got=%b exp=1", t_done); end
        settle();
    endtask

    task automatic test_desc();
        load_and_start(6'b001011);
        @(negedge clk);
        n_tests++; if (d_pe !== 6'b010110) begin n_fail++; $display("FAIL desc_pe got=%b exp=010110", d_pe); end
        n_tests++; if (d_done !== 1'b1) begin n_fail++; $display("FAIL desc_done got=%b exp=1", d_done); end
        settle();
    endtask

    task automatic test_full_sequence();
        logic [5:0] seq [6];
        seq = '{6'b001010, 6'b001010, 6'b010001, 6'b010001, 6'b010001, 6'b010001};
        load_and_start(6'b000111);
        n_tests++; if (def_pe !== 6'b000111) begin n_fail++; $display("FAIL seq_loaded got=%b exp=000111", def_pe); end
        n_tests++; if (def_busy !== 1'b1) begin n_fail++; $display("FAIL seq_busy0 got=%b exp=1", def_busy); end
        for (int k = 0; k < 6; k++) begin
            if (k == 1) begin
                st = 1'b1; lv = 1'b1; lw = 6'b000000;
            end
            @(negedge clk);
            st = 1'b0; lv = 1'b0;
            n_tests++; if (def_pe !== seq[k]) begin n_fail++; $display("FAIL seq_pe[%0d] got=%b exp=%b", k, def_pe, seq[k]); end
            n_tests++; if (def_busy !== (k < 5)) begin n_fail++; $display("FAIL seq_busy[%0d] got=%b exp=%b", k, def_busy, (k < 5)); end
            n_tests++; if (def_done !== (k == 5)) begin n_fail++; $display("FAIL seq_done[%0d] got=%b exp=%b", k, def_done, (k == 5)); end
        end
        @(negedge clk);
        n_tests++; if (def_done !== 1'b0) begin n_fail++; $display("FAIL seq_done_after got=%b exp=0", def_done); end
        n_tests++; if (def_ready !== 1'b1) begin n_fail++; $display("FAIL seq_ready_after got=%b exp=1", def_ready); end
        n_tests++; if (def_pe !== 6'b010001) begin n_fail++; $display("FAIL seq_pe_after got=%b exp=010001", def_pe); end
        settle();
    endtask

    task automatic test_reset_mid_sort();
        logic done_seen;
        load_and_start(6'b000111);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n_tests++; if (def_pe !== 6'b111111) begin n_fail++; $display("FAIL midrst_pe got=%b exp=111111", def_pe); end
        n_tests++; if (def_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", def_busy); end
        n_tests++; if (def_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got=%b exp=1", def_ready); end
        done_seen = def_done;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (def_done === 1'b1) done_seen = 1'b1;
        end
        n_tests++; if (done_seen !== 1'b0) begin n_fail++; $display("FAIL midrst_no_done got=%b exp=0", done_seen); end
        n_tests++; if (def_pe !== 6'b111111) begin n_fail++; $display("FAIL midrst_pe_hold got=%b exp=111111", def_pe); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_asc_swap();
        test_tie();
        test_desc();
        test_full_sequence();
        test_reset_mid_sort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
